// File: rtl/aer_event_arbiter_if.sv
// AER arbiter bus: per-source push handshake plus the
// single decoder-facing output handshake.
interface aer_event_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int WORD_W = 24
);
    localparam int GW = $clog2(N_SRC);

    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*WORD_W-1:0] src_data;
    logic [N_SRC-1:0]        src_ready;
    logic [WORD_W-1:0]       aer_out;
    logic                    aer_valid;
    logic                    aer_ready;
    logic [GW-1:0]           grant_id;

    modport slave (
        input  src_valid, src_data, aer_ready,
        output src_ready, aer_out, aer_valid, grant_id
    );

    modport master (
        output src_valid, src_data, aer_ready,
        input  src_ready, aer_out, aer_valid, grant_id
    );
endinterface

// File: rtl/aer_event_arbiter.sv
// Per-source AER FIFOs drained round-robin into one
// registered valid/ready output stage for the decoder.
module aer_event_arbiter #(
    parameter int N_SRC      = 4,
    parameter int WORD_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clr_overflow,
    output logic [N_SRC-1:0] overflow,
    aer_event_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(N_SRC);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [WORD_W-1:0] mem_q [N_SRC][FIFO_DEPTH];
    logic [AW-1:0]     wr_q  [N_SRC];
    logic [AW-1:0]     rd_q  [N_SRC];
    logic [CW-1:0]     cnt_q [N_SRC];
    logic [CW-1:0]     cnt_d [N_SRC];

    logic [N_SRC-1:0]  push, pop, nempty;
    logic [N_SRC-1:0]  ovf_q, ovf_d;
    logic [GW-1:0]     ptr_q, ptr_d, win;
    logic [GW-1:0]     gid_q, gid_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              vld_q, vld_d;
    logic              found, free, load;
    int                idx;

    // Ready uses only the registered count: a full FIFO
    // never accepts, even when popped in the same cycle.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            bus.src_ready[i] = !rst && (cnt_q[i] != FULL);
            nempty[i]        = (cnt_q[i] != '0);
            push[i]          = bus.src_valid[i] && bus.src_ready[i];
        end
    end

    always_comb begin
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(ptr_q) + k) % N_SRC;
            if (!found && nempty[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    assign free = !vld_q || bus.aer_ready;
    assign load = free && enable && found;

    always_comb begin
        pop   = '0;
        out_d = out_q;
        gid_d = gid_q;
        ptr_d = ptr_q;
        vld_d = vld_q;
        if (load) begin
            pop[win] = 1'b1;
            out_d    = mem_q[win][rd_q[win]];
            gid_d    = win;
            ptr_d    = win;
            vld_d    = 1'b1;
        end else if (free) begin
            vld_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i])
                cnt_d[i] = cnt_q[i] + CW'(1);
            else if (!push[i] && pop[i])
                cnt_d[i] = cnt_q[i] - CW'(1);
        end
    end

    // A drop in the same cycle as a clear must survive.
    assign ovf_d = (ovf_q & ~{N_SRC{clr_overflow}})
                 | (bus.src_valid & ~bus.src_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
            end
            out_q <= '0;
            vld_q <= 1'b0;
            gid_q <= '0;
            ptr_q <= GW'(N_SRC - 1);
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push[i]) wr_q[i] <= wr_q[i] + AW'(1);
                if (pop[i])  rd_q[i] <= rd_q[i] + AW'(1);
            end
            out_q <= out_d;
            vld_q <= vld_d;
            gid_q <= gid_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++)
            if (push[i])
                mem_q[i][wr_q[i]] <= bus.src_data[i*WORD_W +: WORD_W];
    end

    assign bus.aer_out   = out_q;
    assign bus.aer_valid = vld_q;
    assign bus.grant_id  = gid_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_aer_event_arbiter.sv
// Scoreboard bench for aer_event_arbiter: directed pushes
// queue expected words, a negedge monitor checks each accept.
module tb_aer_event_arbiter;
    localparam int N = 4;
    localparam int W = 24;

    typedef struct {
        logic [1:0]   g;
        logic [W-1:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [N-1:0] overflow;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    aer_event_arbiter_if #(.N_SRC(N), .WORD_W(W)) bus ();

    aer_event_arbiter #(
        .N_SRC(N), .WORD_W(W), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .clr_overflow(clr_overflow),
        .overflow(overflow),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(int g, logic [W-1:0] d);
        exp_t e;
        e.g = 2'(g);
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic set_src(int i, logic [W-1:0] d);
        bus.src_valid[i]      = 1'b1;
        bus.src_data[i*W +: W] = d;
    endtask

    function automatic logic [W-1:0] wd(int i, int j);
        return W'(((i + 1) << 20) | ((j + 1) * 'h111));
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.aer_valid && bus.aer_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none",
                         bus.aer_out);
            end else begin
                mon_e = sb.pop_front();
                chk("mon_data", bus.aer_out, mon_e.d);
                chk("mon_grant", bus.grant_id, mon_e.g);
            end
        end
    end

    initial begin
        int hi;
        int guard;
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.aer_ready = 1'b1;
        #2;
        chk("rst_valid", bus.aer_valid, 0);
        chk("rst_out", bus.aer_out, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", bus.src_ready, 4'hf);

        // 1: single word latency
        enable = 1'b1;
        set_src(0, 24'hA12345);
        expect_word(0, 24'hA12345);
        tick();
        bus.src_valid = '0;
        chk("t1_valid_k", bus.aer_valid, 0);
        tick();
        chk("t1_valid_k1", bus.aer_valid, 1);
        chk("t1_out", bus.aer_out, 24'hA12345);
        tick();
        chk("t1_valid_drop", bus.aer_valid, 0);

        // 2: round robin over 8 buffered words
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b0;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < N; i++) set_src(i, wd(i, j));
            tick();
        end
        bus.src_valid = '0;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++) expect_word(i, wd(i, j));
        tick();
        enable = 1'b1;
        tick();
        hi = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.aer_valid) hi++;
            tick();
        end
        chk("t2_valid_cycles", hi, 8);
        chk("t2_valid_end", bus.aer_valid, 0);

        // 3: backpressure holds the word
        bus.aer_ready = 1'b0;
        set_src(3, 24'hA22245);
        tick();
        set_src(3, 24'hB33333);
        tick();
        bus.src_valid = '0;
        expect_word(3, 24'hA22245);
        expect_word(3, 24'hB33333);
        for (int c = 0; c < 10; c++) begin
            chk("t3_hold_out", bus.aer_out, 24'hA22245);
            chk("t3_hold_gid", bus.grant_id, 3);
            chk("t3_hold_vld", bus.aer_valid, 1);
            tick();
        end
        bus.aer_ready = 1'b1;
        tick();
        chk("t3_next_vld", bus.aer_valid, 1);
        chk("t3_next_out", bus.aer_out, 24'hB33333);
        tick();
        chk("t3_idle", bus.aer_valid, 0);

        // 4: fill src2 and overflow
        bus.aer_ready = 1'b0;
        enable = 1'b0;
        for (int n = 0; n < 4; n++) begin
            set_src(2, wd(2, n));
            tick();
        end
        chk("t4_full", bus.src_ready[2], 0);
        set_src(2, wd(2, 4));
        tick();
        bus.src_valid = '0;
        chk("t4_ovf_set", overflow, 4'b0100);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t4_ovf_clr", overflow, 0);
        set_src(2, wd(2, 5));
        clr_overflow = 1'b1;
        tick();
        bus.src_valid = '0;
        clr_overflow = 1'b0;
        chk("t4_set_wins", overflow, 4'b0100);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t4_ovf_clr2", overflow, 0);

        // 5: async reset with output held and 3 buffered
        enable = 1'b1;
        tick();
        chk("t5_held", bus.aer_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_vld", bus.aer_valid, 0);
        chk("t5_async_out", bus.aer_out, 0);
        chk("t5_async_rdy", bus.src_ready, 0);
        tick();
        rst = 1'b0;
        bus.aer_ready = 1'b1;
        tick();
        chk("t5_rdy_after", bus.src_ready, 4'hf);
        hi = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.aer_valid) hi++;
            tick();
        end
        chk("t5_no_stale", hi, 0);
        set_src(1, 24'h1E0001);
        set_src(3, 24'h3E0003);
        expect_word(1, 24'h1E0001);
        expect_word(3, 24'h3E0003);
        tick();
        bus.src_valid = '0;
        tick();
        chk("t5_first_gid", bus.grant_id, 1);
        tick();
        tick();

        // 6: enable low lets FIFO fill, then drains in order
        enable = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_src(1, wd(1, n + 8));
            expect_word(1, wd(1, n + 8));
            tick();
        end
        bus.src_valid = '0;
        hi = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.aer_valid) hi++;
            tick();
        end
        chk("t6_no_load", hi, 0);
        chk("t6_src1_ready", bus.src_ready[1], 1);
        enable = 1'b1;

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
